wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Shares the single register-file write port between NREQ writeback requesters (ALU, load unit, CSR unit).
- Uses round-robin arbitration with a valid/ready handshake per requester.
- Registers the winning write for one cycle, then drives the regfile write port directly: we, rd_addr, rd_data.
- Sits between the execute/memory writeback sources and the regfile.

Parameters:
- NREQ, 3, number of writeback requesters (2..8).
- XLEN, 32, data width.
- AW, 5, register address width.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- req_valid  in  NREQ  per-requester write request
- req_addr  in  NREQ*AW  packed destination register addresses; requester i at bits [i*AW +: AW]
- req_data  in  NREQ*XLEN  packed write data; requester i at bits [i*XLEN +: XLEN]
- req_ready  out  NREQ  one-hot grant; beat accepted when valid && ready
- wb_we  out  1  regfile write enable (registered)
- wb_addr  out  AW  regfile write address (registered)
- wb_data  out  XLEN  regfile write data (registered)
- rs1_addr  in  AW  decode-stage read address 1 (used only with WB_FWD_EN)
- rs2_addr  in  AW  decode-stage read address 2 (used only with WB_FWD_EN)
- rs1_rf  in  XLEN  raw regfile rs1 read data (used only with WB_FWD_EN)
- rs2_rf  in  XLEN  raw regfile rs2 read data (used only with WB_FWD_EN)
- rs1_data  out  XLEN  rs1 operand to decode
- rs2_data  out  XLEN  rs2 operand to decode

Behaviour:
- Reset (async, asserted): wb_we=0, wb_addr=0, wb_data=0, rr_ptr=0. req_ready is all-zero while rst is high.
- Arbitration is combinational in the same cycle:
  - Search req_valid starting at index rr_ptr, wrapping modulo NREQ.
  - The first valid index wins; req_ready is one-hot on the winner, or zero if no request is valid.
- Pointer update, on the clock edge after an accepted beat with winner g: rr_ptr <= (g+1) mod NREQ. With no grant, rr_ptr holds.
- Handshake rules:
  - A requester holds valid, addr and data stable until it sees ready.
  - valid does not drop before acceptance; benches flag a violation.
  - Accepted beats are never lost.
- Latency: a beat accepted in cycle N appears on wb_* in cycle N+1; the regfile commits it at the edge ending N+1.
- Output stage:
  - Accepts every cycle and never backpressures, because the regfile never stalls.
  - wb_we is 1 for exactly one cycle per accepted beat, otherwise 0.
  - wb_addr/wb_data load only on acceptance and otherwise hold their last values.
- x0 writes: a beat with addr==0 is accepted (ready=1, pointer advances), but wb_we stays 0 for that beat.
- Throughput and fairness:
  - One beat per cycle.
  - With all NREQ requesters continuously valid, grants rotate 0,1,..,NREQ-1.
  - Maximum wait from valid to ready is NREQ-1 cycles.
- Mid-operation reset: the registered write is discarded immediately (wb_we falls asynchronously) and the pointer returns to 0. A requester that was waiting must re-present its request after reset.
- rs1_data/rs2_data without forwarding: pass rs1_rf/rs2_rf through unchanged.

Optional Feature:
- Macro: WB_FWD_EN.
- Defined:
  - rs1_data = (wb_we && wb_addr==rs1_addr && rs1_addr!=0) ? wb_data : rs1_rf; rs2_data is formed the same way with rs2_addr/rs2_rf.
  - This covers the write-then-read-same-cycle hazard, since the regfile commits at the clock edge.
  - The bypass is combinational, with no added latency.
- Undefined: rs1_data=rs1_rf and rs2_data=rs2_rf. rs1_addr/rs2_addr are unused, and decode must stall one cycle on this hazard.

Test Plan:
- Single requester, NREQ=3: req 1 valid, addr 5, data 0xDEADBEEF at cycle 0 -> req_ready=3'b010 in cycle 0; in cycle 1 wb_we=1, wb_addr=5, wb_data=0xDEADBEEF; wb_we=0 in cycle 2.
- All three valid continuously for 6 cycles from reset -> grants 0,1,2,0,1,2; wb_addr follows each requester's addr one cycle later.
- x0 drop: req 0 valid, addr 0, data 0x1234 -> req_ready[0]=1 and rr_ptr advances to 1; wb_we stays 0.
- Pointer skip: rr_ptr=1, only req 0 valid -> wrap-around grants req 0; next rr_ptr=1.
- Reset mid-write: assert rst during the cycle wb_we=1 -> wb_we=0 immediately (asynchronously); after release, rr_ptr=0 and wb_we stays 0 until a new grant.
- WB_FWD_EN: wb_we=1, wb_addr=7, wb_data=0xA5A5A5A5, rs1_addr=7, rs1_rf=0 -> rs1_data=0xA5A5A5A5; with rs1_addr=0 -> rs1_data=rs1_rf.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: requester handshakes, regfile write port and
// decode-stage operand read path.
interface wb_arbiter_if #(
  parameter int NREQ = 3,
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*XLEN-1:0] req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 wb_we;
  logic [AW-1:0]        wb_addr;
  logic [XLEN-1:0]      wb_data;
  logic [AW-1:0]        rs1_addr;
  logic [AW-1:0]        rs2_addr;
  logic [XLEN-1:0]      rs1_rf;
  logic [XLEN-1:0]      rs2_rf;
  logic [XLEN-1:0]      rs1_data;
  logic [XLEN-1:0]      rs2_data;

  modport slave (
    input  req_valid, req_addr, req_data, rs1_addr, rs2_addr, rs1_rf, rs2_rf,
    output req_ready, wb_we, wb_addr, wb_data, rs1_data, rs2_data
  );

  modport master (
    output req_valid, req_addr, req_data, rs1_addr, rs2_addr, rs1_rf, rs2_rf,
    input  req_ready, wb_we, wb_addr, wb_data, rs1_data, rs2_data
  );
endinterface

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter in front of the single regfile write port.
// The winning beat is registered for one cycle and drives we/addr/data.
// Optional macro WB_FWD_EN adds a combinational bypass from the registered
// write onto the decode operands (write-then-read-same-cycle hazard).

// Per-lane eligibility: valid and at or above the round-robin pointer.
module wb_arb_lane #(
  parameter int IDX = 0,
  parameter int PW  = 2
) (
  input  logic          valid,
  input  logic [PW-1:0] ptr,
  output logic          hi
);
  assign hi = valid && (PW'(IDX) >= ptr);
endmodule

module wb_arbiter #(
  parameter int NREQ = 3,
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic       clk,
  input  logic       rst,
  wb_arbiter_if.slave bus
);
  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]   rr_ptr;
  logic [NREQ-1:0] hi;
  logic            found;
  logic [PW-1:0]   gnt_idx;
  logic            accept;
  logic [AW-1:0]   gnt_addr;
  logic [XLEN-1:0] gnt_data;

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    wb_arb_lane #(.IDX(i), .PW(PW)) u_lane (
      .valid (bus.req_valid[i]),
      .ptr   (rr_ptr),
      .hi    (hi[i])
    );
  end

  // Winner: lowest eligible index at/above rr_ptr, else wrap to lowest valid.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && hi[i]) begin
        found   = 1'b1;
        gnt_idx = PW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && bus.req_valid[i]) begin
        found   = 1'b1;
        gnt_idx = PW'(i);
      end
    end
  end

  // No grants while reset is held, so nothing is accepted and then dropped.
  assign accept        = found && !rst;
  assign bus.req_ready = accept ? (NREQ'(1) << gnt_idx) : '0;
  assign gnt_addr      = bus.req_addr[gnt_idx*AW +: AW];
  assign gnt_data      = bus.req_data[gnt_idx*XLEN +: XLEN];

  // Pointer moves past the winner after each accepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rr_ptr <= '0;
    else if (accept)
      rr_ptr <= (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
  end

  // Output stage: one-cycle write pulse; x0 beats are consumed without a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.wb_we   <= 1'b0;
      bus.wb_addr <= '0;
      bus.wb_data <= '0;
    end else begin
      bus.wb_we <= accept && (gnt_addr != '0);
      if (accept) begin
        bus.wb_addr <= gnt_addr;
        bus.wb_data <= gnt_data;
      end
    end
  end

`ifdef WB_FWD_EN
  // Bypass the write the regfile commits this edge; x0 never forwards.
  assign bus.rs1_data = (bus.wb_we && bus.wb_addr == bus.rs1_addr && bus.rs1_addr != '0)
                        ? bus.wb_data : bus.rs1_rf;
  assign bus.rs2_data = (bus.wb_we && bus.wb_addr == bus.rs2_addr && bus.rs2_addr != '0)
                        ? bus.wb_data : bus.rs2_rf;
`else
  // Without the bypass, decode stalls on the hazard; operands pass through.
  assign bus.rs1_data = bus.rs1_rf;
  assign bus.rs2_data = bus.rs2_rf;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter (NREQ=3). Inputs change on the falling edge,
// outputs are sampled shortly after.
module tb_wb_arbiter;
  localparam int NREQ = 3;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  wb_arbiter_if #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) bus ();

  wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic set_req(input int idx, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    bus.req_addr[idx*AW +: AW]     = a;
    bus.req_data[idx*XLEN +: XLEN] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.req_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.rs1_addr  = '0;
    bus.rs2_addr  = '0;
    bus.rs1_rf    = '0;
    bus.rs2_rf    = '0;
    rst = 1'b1;
    @(negedge clk);
    bus.req_valid = 3'b111;
    set_req(0, 5'd1, 32'h1);
    #1;
    n_chk++; if (bus.req_ready !== 3'b000) begin n_fail++; $display("FAIL reset_ready got=%b exp=000", bus.req_ready); end
    n_chk++; if (bus.wb_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%b exp=0", bus.wb_we); end
    n_chk++; if (bus.wb_addr !== 5'd0 || bus.wb_data !== 32'd0) begin n_fail++; $display("FAIL reset_wb got=%0d/%h exp=0/0", bus.wb_addr, bus.wb_data); end
    @(negedge clk);
    bus.req_valid = '0;
    rst = 1'b0;
  endtask

  task automatic test_single();
    @(negedge clk);
    set_req(1, 5'd5, 32'hDEADBEEF);
    bus.req_valid = 3'b010;
    #1;
    n_chk++; if (bus.req_ready !== 3'b010) begin n_fail++; $display("FAIL single_ready got=%b exp=010", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    n_chk++; if (bus.wb_we !== 1'b1 || bus.wb_addr !== 5'd5 || bus.wb_data !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL single_wb got=%b/%0d/%h exp=1/5/deadbeef", bus.wb_we, bus.wb_addr, bus.wb_data); end
    @(negedge clk);
    #1;
    n_chk++; if (bus.wb_we !== 1'b0) begin n_fail++; $display("FAIL single_we_drop got=%b exp=0", bus.wb_we); end
  endtask

  task automatic test_rotation();
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(10 + i), 32'h100 + i);
    bus.req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #1;
      n_chk++; if (bus.req_ready !== (3'b001 << (k % 3))) begin
        n_fail++; $display("FAIL rot_ready k=%0d got=%b exp=%b", k, bus.req_ready, 3'b001 << (k % 3)); end
      if (k > 0) begin
        n_chk++; if (bus.wb_we !== 1'b1 || bus.wb_addr !== AW'(10 + (k-1) % 3)) begin
          n_fail++; $display("FAIL rot_wb k=%0d got=%b/%0d exp=1/%0d", k, bus.wb_we, bus.wb_addr, 10 + (k-1) % 3); end
      end
      @(negedge clk);
    end
    bus.req_valid = '0;
    #1;
    n_chk++; if (bus.wb_we !== 1'b1 || bus.wb_addr !== 5'd12 || bus.wb_data !== 32'h102) begin
      n_fail++; $display("FAIL rot_last got=%b/%0d/%h exp=1/12/102", bus.wb_we, bus.wb_addr, bus.wb_data); end
    @(negedge clk);
  endtask

  // Pointer is 0 on entry (last rotation grant was requester 2).
  task automatic test_x0();
    set_req(0, 5'd0, 32'h1234);
    bus.req_valid = 3'b001;
    #1;
    n_chk++; if (bus.req_ready !== 3'b001) begin n_fail++; $display("FAIL x0_ready got=%b exp=001", bus.req_ready); end
    @(negedge clk);
    set_req(0, 5'd20, 32'h20);
    set_req(1, 5'd21, 32'h21);
    set_req(2, 5'd22, 32'h22);
    bus.req_valid = 3'b111;
    #1;
    n_chk++; if (bus.wb_we !== 1'b0) begin n_fail++; $display("FAIL x0_we got=%b exp=0", bus.wb_we); end
    n_chk++; if (bus.req_ready !== 3'b010) begin n_fail++; $display("FAIL x0_ptr_adv got=%b exp=010", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    n_chk++; if (bus.wb_we !== 1'b1 || bus.wb_addr !== 5'd21) begin
      n_fail++; $display("FAIL x0_next_wb got=%b/%0d exp=1/21", bus.wb_we, bus.wb_addr); end
    @(negedge clk);
  endtask

  task automatic test_skip();
    do_reset();
    set_req(0, 5'd4, 32'h44);
    bus.req_valid = 3'b001;
    #1;
    n_chk++; if (bus.req_ready !== 3'b001) begin n_fail++; $display("FAIL skip_first got=%b exp=001", bus.req_ready); end
    @(negedge clk);
    set_req(0, 5'd6, 32'h66);
    #1;
    n_chk++; if (bus.req_ready !== 3'b001) begin n_fail++; $display("FAIL skip_wrap got=%b exp=001", bus.req_ready); end
    n_chk++; if (bus.wb_addr !== 5'd4) begin n_fail++; $display("FAIL skip_wb1 got=%0d exp=4", bus.wb_addr); end
    @(negedge clk);
    bus.req_valid = 3'b111;
    #1;
    n_chk++; if (bus.req_ready !== 3'b010) begin n_fail++; $display("FAIL skip_ptr got=%b exp=010", bus.req_ready); end
    n_chk++; if (bus.wb_we !== 1'b1 || bus.wb_addr !== 5'd6 || bus.wb_data !== 32'h66) begin
      n_fail++; $display("FAIL skip_wb2 got=%b/%0d/%h exp=1/6/66", bus.wb_we, bus.wb_addr, bus.wb_data); end
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_req(2, 5'd9, 32'h99);
    bus.req_valid = 3'b100;
    #1;
    n_chk++; if (bus.req_ready !== 3'b100) begin n_fail++; $display("FAIL rmid_ready got=%b exp=100", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    n_chk++; if (bus.wb_we !== 1'b1) begin n_fail++; $display("FAIL rmid_we_pre got=%b exp=1", bus.wb_we); end
    #1 rst = 1'b1;
    #1;
    n_chk++; if (bus.wb_we !== 1'b0 || bus.wb_addr !== 5'd0 || bus.wb_data !== 32'd0) begin
      n_fail++; $display("FAIL rmid_async got=%b/%0d/%h exp=0/0/0", bus.wb_we, bus.wb_addr, bus.wb_data); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    n_chk++; if (bus.wb_we !== 1'b0) begin n_fail++; $display("FAIL rmid_we_post got=%b exp=0", bus.wb_we); end
    set_req(0, 5'd1, 32'h1);
    set_req(1, 5'd2, 32'h2);
    bus.req_valid = 3'b111;
    #1;
    n_chk++; if (bus.req_ready !== 3'b001) begin n_fail++; $display("FAIL rmid_ptr got=%b exp=001", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
  endtask

  // Pointer is 1 on entry.
  task automatic test_fwd();
    logic [XLEN-1:0] exp1, exp2;
    set_req(1, 5'd7, 32'hA5A5A5A5);
    bus.req_valid = 3'b010;
    #1;
    n_chk++; if (bus.req_ready !== 3'b010) begin n_fail++; $display("FAIL fwd_ready got=%b exp=010", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = '0;
    bus.rs1_addr  = 5'd7;
    bus.rs1_rf    = 32'h0;
    bus.rs2_addr  = 5'd7;
    bus.rs2_rf    = 32'h1111;
`ifdef WB_FWD_EN
    exp1 = 32'hA5A5A5A5;
    exp2 = 32'hA5A5A5A5;
`else
    exp1 = 32'h0;
    exp2 = 32'h1111;
`endif
    #1;
    n_chk++; if (bus.rs1_data !== exp1) begin n_fail++; $display("FAIL fwd_rs1_hit got=%h exp=%h", bus.rs1_data, exp1); end
    n_chk++; if (bus.rs2_data !== exp2) begin n_fail++; $display("FAIL fwd_rs2_hit got=%h exp=%h", bus.rs2_data, exp2); end
    bus.rs1_addr = 5'd0;
    bus.rs1_rf   = 32'h2222;
    #1;
    n_chk++; if (bus.rs1_data !== 32'h2222) begin n_fail++; $display("FAIL fwd_rs1_x0 got=%h exp=2222", bus.rs1_data); end
    @(negedge clk);
    #1;
    n_chk++; if (bus.rs2_data !== 32'h1111) begin n_fail++; $display("FAIL fwd_rs2_idle got=%h exp=1111", bus.rs2_data); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_x0();
    test_skip();
    test_reset_mid();
    test_fwd();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
